// File: rtl/rom_load_pkg.sv
// rtl/rom_load_pkg.sv - shared state encoding and default constants for the ROM loader
package rom_load_pkg;

    typedef enum logic [2:0] {
        ST_NOROM = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TAIL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [16:0] DEF_ROM_BYTES   = 17'h10000;
    localparam int          DEF_TAIL_CYCLES = 1024;
    localparam logic [7:0]  DEF_ROM_INDEX   = 8'd0;
    localparam logic [7:0]  DEF_MOD_INDEX   = 8'd1;
    localparam logic [7:0]  DEF_DIP_INDEX   = 8'd254;

    // Width of a down-counter that must hold cycles-1.
    function automatic int timer_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/rom_load_ctrl_tail_timer.sv
// rtl/rom_load_ctrl_tail_timer.sv - loadable down-counter with zero flag for the reset tail
module tail_timer #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rom_load_ctrl.sv
// rtl/rom_load_ctrl.sv - HPS ioctl download sequencer: ROM write-through, DIP/mod capture, core reset
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter logic [16:0] ROM_BYTES   = DEF_ROM_BYTES,
    parameter int          TAIL_CYCLES = DEF_TAIL_CYCLES,
    parameter logic [7:0]  ROM_INDEX   = DEF_ROM_INDEX,
    parameter logic [7:0]  MOD_INDEX   = DEF_MOD_INDEX,
    parameter logic [7:0]  DIP_INDEX   = DEF_DIP_INDEX
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_ioctl_download,
    input  logic        i_ioctl_wr,
    input  logic [24:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_dout,
    input  logic [7:0]  i_ioctl_index,
    input  logic        i_user_reset,
    output logic        o_rom_we,
    output logic [16:0] o_rom_addr,
    output logic [7:0]  o_rom_data,
    output logic [7:0]  o_sw0,
    output logic [7:0]  o_sw1,
    output logic [7:0]  o_sw2,
    output logic [7:0]  o_mod,
    output logic        o_core_reset,
    output logic        o_rom_ready,
    output logic        o_size_err
);

    localparam int          TW        = timer_width(TAIL_CYCLES);
    localparam logic [TW-1:0] TAIL_LOAD = TW'(TAIL_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_xfer_d;
    logic [16:0] r_cnt;
    logic        r_ovf;
    logic        r_size_err;
    logic        r_core_reset;
    logic        r_rom_ready;
    logic        r_rom_we;
    logic [16:0] r_rom_addr;
    logic [7:0]  r_rom_data;
    logic [7:0]  r_sw0;
    logic [7:0]  r_sw1;
    logic [7:0]  r_sw2;
    logic [7:0]  r_mod;

    logic w_xfer;
    logic w_start;
    logic w_wr;
    logic w_rom_wr;
    logic w_rom_acc;
    logic w_dip_wr;
    logic w_mod_wr;
    logic w_tail_load;
    logic w_tail_zero;

    assign w_xfer    = i_ioctl_download && (i_ioctl_index == ROM_INDEX);
    assign w_start   = w_xfer && !r_xfer_d;
    assign w_wr      = i_ioctl_download && i_ioctl_wr;
    assign w_rom_wr  = w_wr && w_xfer && (r_state == ST_LOAD);
    assign w_rom_acc = w_rom_wr && (i_ioctl_addr < 25'(ROM_BYTES));
    assign w_dip_wr  = w_wr && (i_ioctl_index == DIP_INDEX) &&
                       (i_ioctl_addr[24:2] == '0) && (i_ioctl_addr[1:0] != 2'd3);
    assign w_mod_wr  = w_wr && (i_ioctl_index == MOD_INDEX);

    tail_timer #(
        .W (TW)
    ) u_tail_timer (
        .i_clk      (i_clk_sys),
        .i_rst      (i_reset),
        .i_load     (w_tail_load),
        .i_load_val (TAIL_LOAD),
        .i_en       (r_state == ST_TAIL),
        .o_zero     (w_tail_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tail_load = 1'b0;
        if (w_start) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (!w_xfer) begin
                        if ((r_cnt == ROM_BYTES) && !r_ovf) begin
                            w_state_nxt = ST_TAIL;
                            w_tail_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_ERR;
                        end
                    end
                end
                ST_TAIL: begin
                    if (i_user_reset) begin
                        w_tail_load = 1'b1;
                    end else if (w_tail_zero) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_user_reset) begin
                        w_state_nxt = ST_TAIL;
                        w_tail_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_NOROM;
            // Held high so a transfer still active across reset is not seen as a new start.
            r_xfer_d     <= 1'b1;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_size_err   <= 1'b0;
            r_core_reset <= 1'b1;
            r_rom_ready  <= 1'b0;
            r_rom_we     <= 1'b0;
            r_rom_addr   <= '0;
            r_rom_data   <= '0;
            r_sw0        <= '0;
            r_sw1        <= '0;
            r_sw2        <= '0;
            r_mod        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_xfer_d     <= w_xfer;
            r_core_reset <= (w_state_nxt != ST_RUN);
            r_rom_ready  <= (w_state_nxt == ST_RUN);
            r_rom_we     <= w_rom_acc;

            if (w_start) begin
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
                r_size_err <= 1'b0;
            end else begin
                if (w_rom_acc && (r_cnt != ROM_BYTES)) begin
                    r_cnt <= r_cnt + 17'd1;
                end
                if (w_rom_wr && !w_rom_acc) begin
                    r_ovf <= 1'b1;
                end
                if ((r_state == ST_LOAD) && (w_state_nxt == ST_ERR)) begin
                    r_size_err <= 1'b1;
                end
            end

            if (w_rom_acc) begin
                r_rom_addr <= i_ioctl_addr[16:0];
                r_rom_data <= i_ioctl_dout;
            end

            if (w_dip_wr) begin
                case (i_ioctl_addr[1:0])
                    2'd0:    r_sw0 <= i_ioctl_dout;
                    2'd1:    r_sw1 <= i_ioctl_dout;
                    default: r_sw2 <= i_ioctl_dout;
                endcase
            end

            if (w_mod_wr) begin
                r_mod <= i_ioctl_dout;
            end
        end
    end

    assign o_rom_we     = r_rom_we;
    assign o_rom_addr   = r_rom_addr;
    assign o_rom_data   = r_rom_data;
    assign o_sw0        = r_sw0;
    assign o_sw1        = r_sw1;
    assign o_sw2        = r_sw2;
    assign o_mod        = r_mod;
    assign o_core_reset = r_core_reset;
    assign o_rom_ready  = r_rom_ready;
    assign o_size_err   = r_size_err;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb/tb_rom_load_ctrl.sv - scoreboard bench for rom_load_ctrl
module tb_rom_load_ctrl;

    localparam logic [16:0] ROM_BYTES = 17'h1000;
    localparam int          TAIL      = 1024;
    localparam logic [60:0] RST_VEC   = {1'b0, 17'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        user_reset = 1'b0;
    logic        rom_we;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  sw0, sw1, sw2, mod;
    logic        core_reset, rom_ready, size_err;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    rom_load_ctrl #(
        .ROM_BYTES   (ROM_BYTES),
        .TAIL_CYCLES (TAIL)
    ) dut (
        .i_clk_sys        (clk),
        .i_reset          (rst),
        .i_ioctl_download (ioctl_download),
        .i_ioctl_wr       (ioctl_wr),
        .i_ioctl_addr     (ioctl_addr),
        .i_ioctl_dout     (ioctl_dout),
        .i_ioctl_index    (ioctl_index),
        .i_user_reset     (user_reset),
        .o_rom_we         (rom_we),
        .o_rom_addr       (rom_addr),
        .o_rom_data       (rom_data),
        .o_sw0            (sw0),
        .o_sw1            (sw1),
        .o_sw2            (sw2),
        .o_mod            (mod),
        .o_core_reset     (core_reset),
        .o_rom_ready      (rom_ready),
        .o_size_err       (size_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!rom_ready && n < 5000) begin
            tick();
            n++;
        end
    endtask

    // Drives an index-0 transfer of n bytes, data = addr[7:0] ^ xr, checking each rom_we one cycle later.
    task automatic do_download(input int n, input logic [7:0] xr, input bit drop);
        int   pulses;
        int   want;
        exp_t e;
        pulses = 0;
        want = (n < int'(ROM_BYTES)) ? n : int'(ROM_BYTES);
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            ioctl_addr = 25'(i);
            ioctl_dout = 8'(i) ^ xr;
            ioctl_wr = 1'b1;
            if (i < int'(ROM_BYTES)) sb_q.push_back({17'(i), 8'(i) ^ xr});
            tick();
            ioctl_wr = 1'b0;
            checks++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (rom_we !== 1'b1 || rom_addr !== e.addr || rom_data !== e.data) begin
                    failures++;
                    $display("FAIL rom_write: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                             rom_we, rom_addr, rom_data, e.addr, e.data);
                end
            end else if (rom_we !== 1'b0) begin
                failures++;
                $display("FAIL rom_we_suppressed: addr=%0d we=%b, required 0", i, rom_we);
            end
            if (rom_we === 1'b1) pulses++;
            if ($urandom_range(0, 15) == 0) begin
                tick();
                checks++;
                if (rom_we !== 1'b0) begin
                    failures++;
                    $display("FAIL rom_we_idle: we=%b, required 0", rom_we);
                end
            end
        end
        checks++;
        if (pulses != want) begin
            failures++;
            $display("FAIL rom_we_count: %0d pulses, required %0d", pulses, want);
        end
        if (drop) begin
            ioctl_download = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rom_we, rom_addr, rom_data, sw0, sw1, sw2, mod, core_reset, rom_ready, size_err} !== RST_VEC) begin
            failures++;
            $display("FAIL reset_values: got %h, required %h",
                     {rom_we, rom_addr, rom_data, sw0, sw1, sw2, mod, core_reset, rom_ready, size_err}, RST_VEC);
        end
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (core_reset !== 1'b1 || rom_ready !== 1'b0) begin
            failures++;
            $display("FAIL norom_idle: core_reset=%b rom_ready=%b, required 1/0", core_reset, rom_ready);
        end
    endtask

    task automatic test_good_load(input logic [7:0] xr);
        int n;
        do_download(int'(ROM_BYTES), xr, 1'b1);
        checks++;
        if (core_reset !== 1'b1 || rom_ready !== 1'b0 || size_err !== 1'b0) begin
            failures++;
            $display("FAIL tail_entry: core_reset=%b rom_ready=%b size_err=%b, required 1/0/0",
                     core_reset, rom_ready, size_err);
        end
        wait_ready(n);
        checks++;
        if (n != TAIL) begin
            failures++;
            $display("FAIL tail_length: %0d cycles, required %0d", n, TAIL);
        end
        checks++;
        if (core_reset !== 1'b0 || rom_ready !== 1'b1) begin
            failures++;
            $display("FAIL run_outputs: core_reset=%b rom_ready=%b, required 0/1", core_reset, rom_ready);
        end
    endtask

    task automatic test_dip_mod();
        logic [7:0] bytes [4];
        bytes[0] = 8'h0F; bytes[1] = 8'hC2; bytes[2] = 8'h01; bytes[3] = 8'h55;
        ioctl_index = 8'd254;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            ioctl_addr = 25'(i);
            ioctl_dout = (i < 4) ? bytes[i] : 8'hEE;
            ioctl_wr = 1'b1;
            tick();
            ioctl_wr = 1'b0;
        end
        ioctl_index = 8'd1;
        ioctl_addr = 25'd7;
        ioctl_dout = 8'h3C;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();
        ioctl_index = 8'd254;
        ioctl_addr = 25'd0;
        ioctl_dout = 8'h99;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        ioctl_index = 8'd0;
        tick();
        checks++;
        if ({sw0, sw1, sw2} !== 24'h0FC201) begin
            failures++;
            $display("FAIL dip_bytes: got %h, required 0fc201", {sw0, sw1, sw2});
        end
        checks++;
        if (mod !== 8'h3C) begin
            failures++;
            $display("FAIL mod_byte: got %h, required 3c", mod);
        end
        checks++;
        if (rom_ready !== 1'b1 || core_reset !== 1'b0 || rom_we !== 1'b0) begin
            failures++;
            $display("FAIL dip_run_kept: rom_ready=%b core_reset=%b rom_we=%b, required 1/0/0",
                     rom_ready, core_reset, rom_we);
        end
    endtask

    task automatic test_user_reset_tail();
        int n;
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        checks++;
        if (core_reset !== 1'b1 || rom_ready !== 1'b0) begin
            failures++;
            $display("FAIL run_to_tail: core_reset=%b rom_ready=%b, required 1/0", core_reset, rom_ready);
        end
        repeat (TAIL - 6) tick();
        checks++;
        if (rom_ready !== 1'b0) begin
            failures++;
            $display("FAIL tail_early: rom_ready=%b, required 0", rom_ready);
        end
        user_reset = 1'b1;
        repeat (10) tick();
        user_reset = 1'b0;
        wait_ready(n);
        checks++;
        if (n != TAIL) begin
            failures++;
            $display("FAIL tail_reload: %0d cycles after release, required %0d", n, TAIL);
        end
    endtask

    task automatic test_short();
        do_download(int'(ROM_BYTES) - 1, 8'h5A, 1'b1);
        checks++;
        if (size_err !== 1'b1 || core_reset !== 1'b1 || rom_ready !== 1'b0) begin
            failures++;
            $display("FAIL short_err: size_err=%b core_reset=%b rom_ready=%b, required 1/1/0",
                     size_err, core_reset, rom_ready);
        end
        user_reset = 1'b1;
        repeat (3) tick();
        user_reset = 1'b0;
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        tick();
        ioctl_dout = 8'h77;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        repeat (1500) tick();
        checks++;
        if (size_err !== 1'b1 || core_reset !== 1'b1 || rom_ready !== 1'b0 || mod !== 8'h77) begin
            failures++;
            $display("FAIL err_sticky: size_err=%b core_reset=%b rom_ready=%b mod=%h, required 1/1/0/77",
                     size_err, core_reset, rom_ready, mod);
        end
    endtask

    task automatic test_long();
        do_download(int'(ROM_BYTES) + 1, 8'h33, 1'b1);
        checks++;
        if (size_err !== 1'b1 || core_reset !== 1'b1) begin
            failures++;
            $display("FAIL long_err: size_err=%b core_reset=%b, required 1/1", size_err, core_reset);
        end
        test_good_load(8'hA5);
    endtask

    task automatic test_reset_mid_load();
        do_download(100, 8'hC3, 1'b0);
        rst = 1'b1;
        #2;
        checks++;
        if ({rom_we, rom_addr, rom_data, sw0, sw1, sw2, mod, core_reset, rom_ready, size_err} !== RST_VEC) begin
            failures++;
            $display("FAIL midload_reset: got %h, required %h",
                     {rom_we, rom_addr, rom_data, sw0, sw1, sw2, mod, core_reset, rom_ready, size_err}, RST_VEC);
        end
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
        ioctl_addr = 25'd200;
        ioctl_dout = 8'h42;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        checks++;
        if (rom_we !== 1'b0 || core_reset !== 1'b1 || rom_ready !== 1'b0) begin
            failures++;
            $display("FAIL stay_norom: rom_we=%b core_reset=%b rom_ready=%b, required 0/1/0",
                     rom_we, core_reset, rom_ready);
        end
        ioctl_download = 1'b0;
        repeat (3) tick();
        checks++;
        if ({rom_we, rom_addr, rom_data, sw0, sw1, sw2, mod, core_reset, rom_ready, size_err} !== RST_VEC) begin
            failures++;
            $display("FAIL post_abort: got %h, required %h",
                     {rom_we, rom_addr, rom_data, sw0, sw1, sw2, mod, core_reset, rom_ready, size_err}, RST_VEC);
        end
    endtask

    initial begin
        test_reset();
        test_good_load(8'h00);
        test_dip_mod();
        test_user_reset_tail();
        test_short();
        test_long();
        test_reset_mid_load();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 Parameter ROM_BYTES, 17'h10000; exact ROM image size in bytes the core expects.
REQ-002 Parameter TAIL_CYCLES, 1024; core-reset hold time after download end or user reset, in clk_sys cycles (min 2).
REQ-003 Parameters ROM_INDEX 0, MOD_INDEX 1, DIP_INDEX 254; ioctl_index values that select ROM, mod byte and DIP bank.
REQ-004 clk_sys  in  1  single system clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ioctl_download  in  1  HPS transfer active.
REQ-007 ioctl_wr  in  1  one-cycle byte strobe.
REQ-008 ioctl_addr  in  25  byte address within transfer.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 ioctl_index  in  8  transfer target.
REQ-011 user_reset  in  1  OSD/button reset request, level.
REQ-012 rom_we  out  1  registered ROM write strobe.
REQ-013 rom_addr  out  17  registered ROM write address.
REQ-014 rom_data  out  8  registered ROM write data.
REQ-015 sw0, sw1, sw2  out  8 each  DIP bytes 0..2.
REQ-016 mod  out  8  last mod byte.
REQ-017 core_reset  out  1  reset to game core.
REQ-018 rom_ready  out  1  valid image loaded, core running.
REQ-019 size_err  out  1  last ROM transfer had wrong length.

Function
REQ-020 States: NOROM, LOAD, TAIL, RUN, ERR; encoding in shared package.
REQ-021 ROM transfer = ioctl_download high with ioctl_index==ROM_INDEX; start = rising edge of that condition (one-cycle-delayed copy compared).
REQ-022 Any state, ROM transfer start -> LOAD next cycle; byte counter cleared, size_err cleared.
REQ-023 LOAD: each ioctl_wr with ioctl_addr<ROM_BYTES -> rom_we=1, rom_addr=ioctl_addr[16:0], rom_data=ioctl_dout on next cycle (latency 1); rom_we low otherwise.
REQ-024 LOAD: writes with ioctl_addr>=ROM_BYTES suppressed (no rom_we) and set sticky overflow flag.
REQ-025 LOAD: byte counter increments per accepted write, saturates at ROM_BYTES.
REQ-026 LOAD end (ROM transfer condition falls): counter==ROM_BYTES and no overflow -> TAIL; else -> ERR with size_err=1.
REQ-027 TAIL: down-counter loaded with TAIL_CYCLES-1 on entry; reaching 0 -> RUN; user_reset high reloads counter (stays TAIL).
REQ-028 RUN: user_reset high -> TAIL.
REQ-029 NOROM and ERR leave only on ROM transfer start; user_reset ignored.
REQ-030 core_reset=1 in NOROM, LOAD, TAIL, ERR; 0 only in RUN; registered.
REQ-031 rom_ready=1 only in RUN.
REQ-032 DIP: ioctl_wr, index==DIP_INDEX, ioctl_addr[24:2]==0: addr[1:0] 0..2 writes sw0..sw2; addr 3 and higher ignored; accepted in every state, no effect on FSM.
REQ-033 Mod: ioctl_wr with index==MOD_INDEX writes mod (any address); any state.
REQ-034 Writes with other indices ignored; non-ROM transfers never change state.
REQ-035 ioctl_wr outside ioctl_download ignored.

Reset
REQ-036 Reset: state NOROM, core_reset=1, rom_ready=0, size_err=0, rom_we=0, rom_addr=0, rom_data=0, sw0..sw2=0, mod=0, counters 0.
REQ-037 Reset asserted mid-LOAD aborts transfer; after release, state NOROM until next ROM transfer start.

Structure
REQ-038 Package rom_load_pkg: state enum, default index constants, ROM_BYTES default.
REQ-039 One sub-module natural: tail_timer (loadable down-counter with zero flag) used in TAIL.

Verification
REQ-040 Download 65536 bytes index 0, data=addr[7:0] -> 65536 rom_we pulses, each 1 cycle after ioctl_wr; TAIL 1024 cycles; then rom_ready=1, core_reset=0.
REQ-041 Download 65535 bytes -> ERR, size_err=1, core_reset stays 1 indefinitely; user_reset pulse has no effect.
REQ-042 Download 65537 bytes -> last write no rom_we, ERR, size_err=1; new correct download -> size_err=0, RUN.
REQ-043 In RUN, index 254 bytes 0x0F,0xC2,0x01,0x55 at addr 0..3 -> sw0=0x0F, sw1=0xC2, sw2=0x01, 4th ignored; rom_ready stays 1.
REQ-044 user_reset held 10 cycles in TAIL at count 5 -> RUN reached exactly 1024 cycles after user_reset release; reset asserted mid-LOAD -> NOROM, all outputs at reset values.
